// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, record widths and field positions, memory-stage states.
package cpu_pkg;

  localparam int EX_W  = 74;
  localparam int MEM_W = 38;

  // Execute-result record fields
  localparam int EX_VALID   = 73;
  localparam int EX_OP_HI   = 72;
  localparam int EX_OP_LO   = 69;
  localparam int EX_DEST_HI = 68;
  localparam int EX_DEST_LO = 64;
  localparam int EX_ANS_HI  = 63;
  localparam int EX_ANS_LO  = 32;
  localparam int EX_VAL_HI  = 31;
  localparam int EX_VAL_LO  = 0;

  // Write-back record fields
  localparam int MEM_VALID   = 37;
  localparam int MEM_DEST_HI = 36;
  localparam int MEM_DEST_LO = 32;
  localparam int MEM_DATA_HI = 31;
  localparam int MEM_DATA_LO = 0;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_RD = 2'd1,
    ST_WAIT_WR = 2'd2
  } mem_state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHR, OP_SHL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [MEM_W-1:0] wb_record(input logic [4:0] dest, input logic [31:0] data);
    logic [MEM_W-1:0] rec;
    rec = '0;
    rec[MEM_VALID] = 1'b1;
    rec[MEM_DEST_HI:MEM_DEST_LO] = dest;
    rec[MEM_DATA_HI:MEM_DATA_LO] = data;
    return rec;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle counter and sticky bus error for the memory stage (used with MEM_TIMEOUT_EN).
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_waiting,
  input  logic i_ack,
  output logic o_timeout,
  output logic o_bus_err
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;

  // Fires during the last allowed wait cycle so the abort lands on that edge.
  assign o_timeout = i_waiting && !i_ack && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_bus_err = r_bus_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (i_start) begin
        r_cnt <= '0;
      end else if (i_waiting && !i_ack) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if (o_timeout) begin
        r_bus_err <= 1'b1;
      end else begin
        r_bus_err <= r_bus_err;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU pass-through and load/store over a req/ack handshake.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [EX_W-1:0]   ex_result,
  output logic [MEM_W-1:0]  mem_result,
  output logic [4:0]        mem_dest,
  output logic              delay,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              bus_err
);

  logic        w_valid;
  logic [3:0]  w_op;
  logic [4:0]  w_dest;
  logic [31:0] w_answer;
  logic [31:0] w_value;

  mem_state_e       r_state, w_state_nxt;
  logic [MEM_W-1:0] r_result, w_result_nxt;
  logic             r_req, w_req_nxt;
  logic             r_we, w_we_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic [4:0]       r_dest, w_dest_nxt;
  logic             w_timeout;

  assign w_valid  = ex_result[EX_VALID];
  assign w_op     = ex_result[EX_OP_HI:EX_OP_LO];
  assign w_dest   = ex_result[EX_DEST_HI:EX_DEST_LO];
  assign w_answer = ex_result[EX_ANS_HI:EX_ANS_LO];
  assign w_value  = ex_result[EX_VAL_HI:EX_VAL_LO];

  assign mem_result = r_result;
  assign mem_req    = r_req;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;

`ifdef MEM_TIMEOUT_EN
  logic w_wait_start;
  logic w_waiting;

  assign w_wait_start = (r_state == ST_IDLE) && (w_state_nxt != ST_IDLE);
  assign w_waiting    = (r_state != ST_IDLE);

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W(CNT_W)
  ) u_watchdog (
    .clk(clk),
    .reset(reset),
    .i_start(w_wait_start),
    .i_waiting(w_waiting),
    .i_ack(mem_ack),
    .o_timeout(w_timeout),
    .o_bus_err(bus_err)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // A timeout completes the access like an ack, so upstream advances and nothing is reissued.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = '0;
    w_req_nxt    = r_req;
    w_we_nxt     = r_we;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_dest_nxt   = r_dest;
    delay        = 1'b0;
    mem_dest     = 5'd0;
    case (r_state)
      ST_IDLE: begin
        mem_dest = (w_valid && (w_op != OP_SW)) ? w_dest : 5'd0;
        if (w_valid && is_alu_op(w_op)) begin
          w_result_nxt = wb_record(w_dest, w_answer);
        end else if (w_valid && (w_op == OP_LW)) begin
          delay       = 1'b1;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = w_answer;
          w_dest_nxt  = w_dest;
          w_state_nxt = ST_WAIT_RD;
        end else if (w_valid && (w_op == OP_SW)) begin
          delay       = 1'b1;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = w_answer;
          w_wdata_nxt = w_value;
          w_dest_nxt  = 5'd0;
          w_state_nxt = ST_WAIT_WR;
        end else begin
          w_result_nxt = '0;
        end
      end
      ST_WAIT_RD: begin
        mem_dest = r_dest;
        if (mem_ack) begin
          w_result_nxt = wb_record(r_dest, mem_rdata);
          w_req_nxt    = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else if (w_timeout) begin
          w_result_nxt = wb_record(r_dest, 32'h0000_0000);
          w_req_nxt    = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else begin
          delay = 1'b1;
        end
      end
      ST_WAIT_WR: begin
        mem_dest = 5'd0;
        if (mem_ack || w_timeout) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          delay = 1'b1;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Stage registers; reset drops mem_req, which the memory treats as an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
      r_dest   <= 5'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_req    <= w_req_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_dest   <= w_dest_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [73:0] ex_result = '0;
  logic [37:0] mem_result;
  logic [4:0]  mem_dest;
  logic        delay;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ex_result(ex_result),
    .mem_result(mem_result), .mem_dest(mem_dest), .delay(delay),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decoded view of the instruction offered by upstream
  logic        e_valid;
  logic [3:0]  e_op;
  logic [4:0]  e_dest;
  logic [31:0] e_ans, e_val;
  assign e_valid = ex_result[73];
  assign e_op    = ex_result[72:69];
  assign e_dest  = ex_result[68:64];
  assign e_ans   = ex_result[63:32];
  assign e_val   = ex_result[31:0];

  // Reference model: one outstanding memory transaction at most
  bit          m_ready = 1'b0;
  logic [37:0] m_res = '0;
  bit          m_pend = 1'b0;
  bit          m_load = 1'b0;
  logic [4:0]  m_dest = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  int          m_waits = 0;
  bit          m_err = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_ready <= 1'b1;
      m_res   <= '0;
      m_pend  <= 1'b0;
      m_err   <= 1'b0;
      m_waits <= 0;
    end else if (m_pend) begin
      if (mem_ack) begin
        m_res  <= m_load ? {1'b1, m_dest, mem_rdata} : 38'd0;
        m_pend <= 1'b0;
      end else if (TO_EN && (m_waits + 1 == TO)) begin
        m_res  <= m_load ? {1'b1, m_dest, 32'd0} : 38'd0;
        m_pend <= 1'b0;
        m_err  <= 1'b1;
      end else begin
        m_res   <= '0;
        m_waits <= m_waits + 1;
      end
    end else begin
      if (e_valid && e_op >= 4'd1 && e_op <= 4'd7) begin
        m_res <= {1'b1, e_dest, e_ans};
      end else if (e_valid && (e_op == 4'd8 || e_op == 4'd9)) begin
        m_pend  <= 1'b1;
        m_load  <= (e_op == 4'd8);
        m_dest  <= e_dest;
        m_addr  <= e_ans;
        m_wdata <= e_val;
        m_waits <= 0;
        m_res   <= '0;
      end else begin
        m_res <= '0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ready) begin
      chk("m_result", mem_result, m_res);
      chk("m_req", mem_req, m_pend);
      chk("m_bus_err", bus_err, m_err);
      chk("m_delay", delay, m_pend ? !(mem_ack || (TO_EN && (m_waits + 1 == TO)))
                                   : (e_valid && (e_op == 4'd8 || e_op == 4'd9)));
      chk("m_dest", mem_dest, m_pend ? (m_load ? m_dest : 5'd0)
                                     : ((e_valid && e_op != 4'd9) ? e_dest : 5'd0));
      if (m_pend) begin
        chk("m_we", mem_we, !m_load);
        chk("m_addr", mem_addr, m_addr);
        if (!m_load) chk("m_wdata", mem_wdata, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [3:0] op, input logic [4:0] d,
                        input logic [31:0] ans, input logic [31:0] val);
    ex_result = {v, op, d, ans, val};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_result", mem_result, 38'd0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);

    // ALU pass-through
    set_ex(1'b1, 4'b0001, 5'd3, 32'h0000_0005, 32'h0);
    #1 chk("alu_delay", delay, 1'b0);
    tick();
    set_ex(1'b0, 4'b0000, 5'd0, 32'h0, 32'h0);
    chk("alu_wb", mem_result, {1'b1, 5'd3, 32'h0000_0005});

    // Load acked in the third wait cycle, then an add right behind it
    set_ex(1'b1, 4'b1000, 5'd7, 32'h0000_0100, 32'h0);
    #1 chk("lw_issue_delay", delay, 1'b1);
    chk("lw_issue_dest", mem_dest, 5'd7);
    tick();
    chk("lw_w1_req", mem_req, 1'b1);
    chk("lw_w1_we", mem_we, 1'b0);
    chk("lw_w1_addr", mem_addr, 32'h0000_0100);
    chk("lw_w1_dest", mem_dest, 5'd7);
    chk("lw_w1_bubble", mem_result, 38'd0);
    tick();
    chk("lw_w2_addr", mem_addr, 32'h0000_0100);
    chk("lw_w2_delay", delay, 1'b1);
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    #1 chk("lw_ack_delay", delay, 1'b0);
    chk("lw_w3_addr", mem_addr, 32'h0000_0100);
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    set_ex(1'b1, 4'b0001, 5'd9, 32'h0000_0077, 32'h0);
    chk("lw_wb", mem_result, {1'b1, 5'd7, 32'hCAFE_F00D});
    chk("lw_req_drop", mem_req, 1'b0);
    tick();
    set_ex(1'b0, 4'b0000, 5'd0, 32'h0, 32'h0);
    chk("add_after_lw", mem_result, {1'b1, 5'd9, 32'h0000_0077});
    chk("lw_not_reissued", mem_req, 1'b0);

    // Store acked in the second wait cycle
    set_ex(1'b1, 4'b1001, 5'd5, 32'h0000_0200, 32'h0000_1234);
    #1 chk("sw_issue_dest", mem_dest, 5'd0);
    chk("sw_issue_delay", delay, 1'b1);
    tick();
    chk("sw_we", mem_we, 1'b1);
    chk("sw_wdata", mem_wdata, 32'h0000_1234);
    chk("sw_addr", mem_addr, 32'h0000_0200);
    chk("sw_dest", mem_dest, 5'd0);
    chk("sw_valid", mem_result[37], 1'b0);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    set_ex(1'b0, 4'b0000, 5'd0, 32'h0, 32'h0);
    chk("sw_no_wb", mem_result, 38'd0);
    chk("sw_req_drop", mem_req, 1'b0);

    // Stray ack while idle
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_result", mem_result, 38'd0);

    // Unused opcode and invalid entry
    set_ex(1'b1, 4'b1010, 5'd6, 32'h0000_0055, 32'h0);
    #1 chk("badop_dest", mem_dest, 5'd6);
    chk("badop_delay", delay, 1'b0);
    tick();
    chk("badop_result", mem_result, 38'd0);
    set_ex(1'b0, 4'b0001, 5'd6, 32'h0000_0055, 32'h0);
    #1 chk("invalid_dest", mem_dest, 5'd0);
    tick();
    chk("invalid_result", mem_result, 38'd0);

    // Reset while a load waits; the late ack must be discarded
    set_ex(1'b1, 4'b1000, 5'd4, 32'h0000_0300, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_ex(1'b0, 4'b0000, 5'd0, 32'h0, 32'h0);
    chk("rstw_req", mem_req, 1'b0);
    chk("rstw_result", mem_result, 38'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("rstw_late_ack", mem_result, 38'd0);

`ifdef MEM_TIMEOUT_EN
    // Ack in the final allowed wait cycle beats the timeout
    set_ex(1'b1, 4'b1000, 5'd2, 32'h0000_0400, 32'h0);
    tick(); tick(); tick(); tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_1111;
    tick();
    mem_ack = 1'b0;
    set_ex(1'b0, 4'b0000, 5'd0, 32'h0, 32'h0);
    chk("to_race_wb", mem_result, {1'b1, 5'd2, 32'h0000_1111});
    chk("to_race_err", bus_err, 1'b0);

    // Load never acked
    set_ex(1'b1, 4'b1000, 5'd6, 32'h0000_0500, 32'h0);
    tick();
    tick(); tick(); tick();
    chk("to_w4_req", mem_req, 1'b1);
    tick();
    set_ex(1'b0, 4'b0000, 5'd0, 32'h0, 32'h0);
    chk("to_req", mem_req, 1'b0);
    chk("to_err", bus_err, 1'b1);
    chk("to_wb", mem_result, {1'b1, 5'd6, 32'h0});
    tick(); tick();
    chk("to_err_sticky", bus_err, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("to_err_cleared", bus_err, 1'b0);
`else
    // Without the timeout the stage waits as long as it takes
    set_ex(1'b1, 4'b1000, 5'd2, 32'h0000_0400, 32'h0);
    tick();
    tick(); tick(); tick(); tick(); tick();
    chk("long_wait_req", mem_req, 1'b1);
    chk("long_wait_err", bus_err, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_2222;
    tick();
    mem_ack = 1'b0;
    set_ex(1'b0, 4'b0000, 5'd0, 32'h0, 32'h0);
    chk("long_wait_wb", mem_result, {1'b1, 5'd2, 32'h0000_2222});
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the 74-bit registered execute result and performs data-memory loads and stores over a req/ack handshake.
- Passes ALU results through unchanged.
- Produces a 38-bit write-back record, a stall (delay) back to the upstream stages, and the in-flight destination register for hazard checks.

Parameters:
- TIMEOUT_CYCLES, 255: wait-cycle limit before a memory access is aborted. Used only with MEM_TIMEOUT_EN.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ex_result  in  74  fields:
  - [73] valid
  - [72:69] opcode
  - [68:64] dest
  - [63:32] answer (ALU result or address)
  - [31:0] value (store data)
- mem_result  out  74→38 write-back record, 38 bits: [37] valid, [36:32] dest, [31:0] data. Registered.
- mem_dest  out  5  destination of the instruction held in this stage; 0 if none or store. Combinational.
- delay  out  1  stall to upstream stages. Combinational.
- mem_req  out  1  memory request. Registered.
- mem_we  out  1  1 = write, 0 = read. Registered.
- mem_addr  out  32  memory address. Registered.
- mem_wdata  out  32  store data. Registered.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  32  load data, valid with mem_ack.
- bus_err  out  1  sticky timeout flag. Tied 0 unless MEM_TIMEOUT_EN.

Behaviour:
- Reset: state IDLE; mem_result, mem_req, mem_we, mem_addr, mem_wdata, bus_err all 0.
- States: IDLE, WAIT_RD, WAIT_WR.
- IDLE, valid, opcode 0001–0111 (ALU): at the next edge mem_result <= {1, dest, answer}. delay=0. Latency 1 cycle.
- IDLE, valid, opcode 1000 (lw):
  - delay=1 this cycle.
  - At the edge: mem_req<=1, mem_we<=0, mem_addr<=answer; capture dest; go to WAIT_RD.
  - mem_result <= 0 (bubble).
- IDLE, valid, opcode 1001 (sw):
  - delay=1 this cycle.
  - At the edge: mem_req<=1, mem_we<=1, mem_addr<=answer, mem_wdata<=value; go to WAIT_WR.
  - mem_result <= 0.
- IDLE, invalid or other opcode (0000, 1010–1111): mem_result <= 0. delay=0.
- WAIT_RD / WAIT_WR:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled high.
  - delay=1 except in the cycle where mem_ack=1.
  - On mem_ack in WAIT_RD: mem_result <= {1, captured dest, mem_rdata}; mem_req<=0; go to IDLE.
  - On mem_ack in WAIT_WR: mem_result <= 0 (stores never write back); mem_req<=0; go to IDLE.
- Upstream advances on the mem_ack edge. The next instruction is evaluated in IDLE on the following cycle, so the same load/store is never issued twice.
- Minimum load latency is 2 cycles (issue plus ack). Back-to-back loads are therefore spaced 2 cycles minimum.
- mem_ack while mem_req=0 is ignored.
- mem_dest:
  - captured dest in WAIT_RD;
  - 0 in WAIT_WR;
  - in IDLE: ex dest if valid and not sw, else 0.
- Reset mid-access: at that edge mem_req drops, the state goes to IDLE and any pending mem_ack is discarded. The memory treats a dropped req as an abort.
- Address and data are 32-bit. No alignment check; memory handles byte/word interpretation.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Enabled:
  - A CNT_W counter clears on entry to a WAIT state and increments each wait cycle.
  - If it reaches TIMEOUT_CYCLES without mem_ack: mem_req<=0, go to IDLE, bus_err<=1 (sticky until reset).
  - A timed-out load writes back {1, dest, 32'h0000_0000}; a timed-out store writes back 0.
  - mem_ack in the same cycle as the timeout wins: normal completion, no error.
- Disabled: the stage waits indefinitely for mem_ack; bus_err is constant 0; no counter logic is present.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD=0001 … OP_SHL=0111, OP_LW=1000, OP_SW=1001;
  - EX_W=74 and MEM_W=38;
  - field bit positions for both records;
  - the state enum.
- Sub-module mem_watchdog (counter plus sticky error), instantiated only under MEM_TIMEOUT_EN. The FSM stays in mem_stage.

Test Plan:
- ALU pass-through: ex_result={1,0001,dest 3,answer 0x0000_0005,value 0} → next cycle mem_result={1,3,0x5}; delay=0 throughout.
- Load with ack at 3rd wait cycle: lw dest 7, addr 0x100 → mem_req=1, mem_we=0, mem_addr=0x100 held 3 cycles; delay=1 until ack. On ack, mem_rdata=0xCAFE_F00D → mem_result={1,7,0xCAFEF00D}; mem_dest=7 during wait.
- Store: sw addr 0x200, value 0x1234 → mem_we=1, mem_wdata=0x1234 until ack; mem_result.valid stays 0; mem_dest=0.
- Back-to-back lw then add: add result appears exactly 1 cycle after the lw write-back; the lw is not reissued.
- Reset asserted in WAIT_RD: next cycle mem_req=0, state IDLE, mem_result=0. A late mem_ack produces no write-back.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, lw never acked: after 4 wait cycles mem_req=0, bus_err=1, mem_result={1,dest,0}. bus_err stays 1 until reset.
